// File: rtl/stall_arbiter.sv
// stall_arbiter
// Merges two request channels into one registered downstream beat.
// Each channel buffers beats in its own 2-entry FIFO; a round-robin
// pointer picks between the surviving FIFO heads whenever the output
// register is free. A per-channel flush discards every beat of that
// channel carrying the flush ID: buffered entries, the beat being
// accepted this cycle, and a stalled output beat. Discarded beats are
// counted in a saturating 8-bit drop counter.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_address_N, in_id_N, in_valid_N  channel N request beat (N = 1, 2)
//   out_stall_N                      backpressure to channel N (FIFO full)
//   flush_N, flush_id_N              channel N flush request and target ID
//   out_address, out_id, out_valid   merged downstream beat
//   out_src                          0 = beat came from channel 1, 1 = channel 2
//   in_stall                         downstream backpressure
//   drop_count                       saturating count of flushed beats
//
// ADDRESS_WIDTH and ID_WIDTH are project-wide macros from defines.vh;
// the fallbacks below only apply when that header has not been seen.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module stall_arbiter (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`ADDRESS_WIDTH-1:0] in_address_1,
    input  logic [`ID_WIDTH-1:0]      in_id_1,
    input  logic                      in_valid_1,
    output logic                      out_stall_1,
    input  logic                      flush_1,
    input  logic [`ID_WIDTH-1:0]      flush_id_1,
    input  logic [`ADDRESS_WIDTH-1:0] in_address_2,
    input  logic [`ID_WIDTH-1:0]      in_id_2,
    input  logic                      in_valid_2,
    output logic                      out_stall_2,
    input  logic                      flush_2,
    input  logic [`ID_WIDTH-1:0]      flush_id_2,
    output logic [`ADDRESS_WIDTH-1:0] out_address,
    output logic [`ID_WIDTH-1:0]      out_id,
    output logic                      out_valid,
    output logic                      out_src,
    input  logic                      in_stall,
    output logic [7:0]                drop_count
);

    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;
    localparam int EW = AW + IW;

    // Saturating add of this cycle's drops onto the running count.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Per-channel views, index 0 = channel 1, index 1 = channel 2.
    // Entries are packed {address, id} so the id is the low field.
    logic [EW-1:0] in_beat  [2];
    logic          in_valid [2];
    logic          flush    [2];
    logic [IW-1:0] flush_id [2];

    logic [EW-1:0] fifo_q   [2][2];
    logic [EW-1:0] fifo_d   [2][2];
    logic [1:0]    count_q  [2];
    logic [1:0]    count_d  [2];
    logic          rr_q, rr_d;          // 0 = channel 1 has priority

    logic          hit0     [2];
    logic          hit1     [2];
    logic          keep0    [2];
    logic          keep1    [2];
    logic [1:0]    surv_cnt [2];
    logic [EW-1:0] surv     [2][2];
    logic          head_ok  [2];
    logic          accept   [2];
    logic          in_hit   [2];
    logic          push     [2];
    logic          pop      [2];
    logic [1:0]    rem_cnt  [2];
    logic [1:0]    ch_drops [2];

    logic          load, grant, gsel, out_hit;
    logic [3:0]    drop_now;

    logic                 out_valid_d, out_src_d;
    logic [AW-1:0]        out_address_d;
    logic [IW-1:0]        out_id_d;

    always_comb begin
        in_beat[0]  = {in_address_1, in_id_1};
        in_beat[1]  = {in_address_2, in_id_2};
        in_valid[0] = in_valid_1;
        in_valid[1] = in_valid_2;
        flush[0]    = flush_1;
        flush[1]    = flush_2;
        flush_id[0] = flush_id_1;
        flush_id[1] = flush_id_2;
    end

    assign out_stall_1 = (count_q[0] == 2'd2);
    assign out_stall_2 = (count_q[1] == 2'd2);

    always_comb begin
        // Flush filtering and compaction of the buffered entries; the
        // compacted head is what arbitration sees, so a flushed head is
        // never eligible.
        for (int c = 0; c < 2; c++) begin
            hit0[c]     = flush[c] && (fifo_q[c][0][IW-1:0] == flush_id[c]);
            hit1[c]     = flush[c] && (fifo_q[c][1][IW-1:0] == flush_id[c]);
            keep0[c]    = (count_q[c] != 2'd0) && !hit0[c];
            keep1[c]    = (count_q[c] == 2'd2) && !hit1[c];
            surv_cnt[c] = {1'b0, keep0[c]} + {1'b0, keep1[c]};
            surv[c][0]  = keep0[c] ? fifo_q[c][0] : fifo_q[c][1];
            surv[c][1]  = fifo_q[c][1];
            head_ok[c]  = (surv_cnt[c] != 2'd0);
            // Acceptance depends on the registered count only, so a
            // flush that frees space does not open the door this cycle.
            accept[c]   = in_valid[c] && (count_q[c] != 2'd2);
            in_hit[c]   = flush[c] && (in_beat[c][IW-1:0] == flush_id[c]);
            push[c]     = accept[c] && !in_hit[c];
            ch_drops[c] = {1'b0, (count_q[c] != 2'd0) && hit0[c]}
                        + {1'b0, (count_q[c] == 2'd2) && hit1[c]}
                        + {1'b0, accept[c] && in_hit[c]};
        end

        load  = !out_valid || !in_stall;
        grant = load && (head_ok[0] || head_ok[1]);
        gsel  = (head_ok[0] && head_ok[1]) ? rr_q : head_ok[1];

        for (int c = 0; c < 2; c++) begin
            pop[c]       = grant && (gsel == 1'(c));
            rem_cnt[c]   = surv_cnt[c] - {1'b0, pop[c]};
            fifo_d[c][0] = pop[c] ? surv[c][1] : surv[c][0];
            fifo_d[c][1] = surv[c][1];
            if (push[c]) begin
                if (rem_cnt[c] == 2'd0) fifo_d[c][0] = in_beat[c];
                else                    fifo_d[c][1] = in_beat[c];
            end
            count_d[c] = rem_cnt[c] + {1'b0, push[c]};
        end

        // A stalled output beat can only be flushed when no load happens,
        // which is guaranteed since load needs out_valid=0 or in_stall=0.
        out_hit = out_valid && in_stall && flush[out_src] && (out_id == flush_id[out_src]);

        drop_now = {2'b0, ch_drops[0]} + {2'b0, ch_drops[1]} + {3'b0, out_hit};

        out_valid_d   = out_valid;
        out_src_d     = out_src;
        out_address_d = out_address;
        out_id_d      = out_id;
        rr_d          = rr_q;
        if (grant) begin
            out_valid_d   = 1'b1;
            out_src_d     = gsel;
            out_address_d = surv[gsel][0][EW-1:IW];
            out_id_d      = surv[gsel][0][IW-1:0];
            rr_d          = ~gsel;
        end else if (load || out_hit) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q[0]  <= 2'd0;
            count_q[1]  <= 2'd0;
            rr_q        <= 1'b0;
            out_valid   <= 1'b0;
            out_src     <= 1'b0;
            out_address <= '0;
            out_id      <= '0;
            drop_count  <= 8'd0;
        end else begin
            count_q[0]  <= count_d[0];
            count_q[1]  <= count_d[1];
            rr_q        <= rr_d;
            out_valid   <= out_valid_d;
            out_src     <= out_src_d;
            out_address <= out_address_d;
            out_id      <= out_id_d;
            drop_count  <= sat_add(drop_count, drop_now);
        end
    end

    // FIFO storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int e = 0; e < 2; e++) begin
                fifo_q[c][e] <= fifo_d[c][e];
            end
        end
    end

endmodule

// File: tb/tb_stall_arbiter.sv
// Directed bench for stall_arbiter: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written sequences for drop
// counter saturation and reset in the middle of traffic.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_stall_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_address_1 = 8'h0, in_id_1 = 8'h0, flush_id_1 = 8'h0;
    logic [7:0] in_address_2 = 8'h0, in_id_2 = 8'h0, flush_id_2 = 8'h0;
    logic       in_valid_1 = 1'b0, in_valid_2 = 1'b0;
    logic       flush_1 = 1'b0, flush_2 = 1'b0;
    logic       in_stall = 1'b0;
    logic       out_stall_1, out_stall_2, out_valid, out_src;
    logic [7:0] out_address, out_id, drop_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stall_arbiter dut (
        .clk(clk), .reset(reset),
        .in_address_1(in_address_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1),
        .out_stall_1(out_stall_1), .flush_1(flush_1), .flush_id_1(flush_id_1),
        .in_address_2(in_address_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2),
        .out_stall_2(out_stall_2), .flush_2(flush_2), .flush_id_2(flush_id_2),
        .out_address(out_address), .out_id(out_id), .out_valid(out_valid),
        .out_src(out_src), .in_stall(in_stall), .drop_count(drop_count)
    );

    // Addresses are tied to ids so the address path is checked too.
    function automatic logic [7:0] addr1(input logic [7:0] id); return id ^ 8'h15; endfunction
    function automatic logic [7:0] addr2(input logic [7:0] id); return id ^ 8'h2A; endfunction

    typedef struct {
        bit       rst;
        bit       v1;  logic [7:0] id1;
        bit       v2;  logic [7:0] id2;
        bit       f1;  logic [7:0] fid1;
        bit       f2;  logic [7:0] fid2;
        bit       stl;
        bit       e_ov; logic [7:0] e_id; bit e_src;
        bit       e_st1; bit e_st2; logic [7:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit v1, logic [7:0] id1, bit v2, logic [7:0] id2,
                                bit f1, logic [7:0] fid1, bit f2, logic [7:0] fid2, bit stl,
                                bit e_ov, logic [7:0] e_id, bit e_src,
                                bit e_st1, bit e_st2, logic [7:0] e_drop);
        vec_t v;
        v.rst = rst; v.v1 = v1; v.id1 = id1; v.v2 = v2; v.id2 = id2;
        v.f1 = f1; v.fid1 = fid1; v.f2 = f2; v.fid2 = fid2; v.stl = stl;
        v.e_ov = e_ov; v.e_id = e_id; v.e_src = e_src;
        v.e_st1 = e_st1; v.e_st2 = e_st2; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid_1 = 0; in_valid_2 = 0; flush_1 = 0; flush_2 = 0; in_stall = 0;
        in_id_1 = 0; in_id_2 = 0; in_address_1 = 0; in_address_2 = 0;
        flush_id_1 = 0; flush_id_2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic drive(input vec_t v);
        in_valid_1 = v.v1; in_id_1 = v.id1; in_address_1 = addr1(v.id1);
        in_valid_2 = v.v2; in_id_2 = v.id2; in_address_2 = addr2(v.id2);
        flush_1 = v.f1; flush_id_1 = v.fid1;
        flush_2 = v.f2; flush_id_2 = v.fid2;
        in_stall = v.stl;
    endtask

    task automatic check_vec(input int n, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", n);
        chk({tag, ".out_valid"},   {31'b0, out_valid},   {31'b0, v.e_ov});
        chk({tag, ".out_stall_1"}, {31'b0, out_stall_1}, {31'b0, v.e_st1});
        chk({tag, ".out_stall_2"}, {31'b0, out_stall_2}, {31'b0, v.e_st2});
        chk({tag, ".drop_count"},  {24'b0, drop_count},  {24'b0, v.e_drop});
        if (v.e_ov) begin
            chk({tag, ".out_id"},      {24'b0, out_id},      {24'b0, v.e_id});
            chk({tag, ".out_src"},     {31'b0, out_src},     {31'b0, v.e_src});
            chk({tag, ".out_address"}, {24'b0, out_address},
                {24'b0, v.e_src ? addr2(v.e_id) : addr1(v.e_id)});
        end
    endtask

    initial begin
        // Single beat: accepted at the first edge, visible after the next.
        vecs.push_back(mk(1, 1,8'h11, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'h11,0, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd0));
        // Contention: producers hold their beat while stalled.
        vecs.push_back(mk(1, 1,8'hA1, 1,8'hB1, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd0));
        vecs.push_back(mk(0, 1,8'hA2, 1,8'hB2, 0,8'h00, 0,8'h00, 0, 1,8'hA1,0, 0,1,8'd0));
        vecs.push_back(mk(0, 1,8'hA3, 1,8'hB3, 0,8'h00, 0,8'h00, 0, 1,8'hB1,1, 1,0,8'd0));
        vecs.push_back(mk(0, 1,8'hA4, 1,8'hB3, 0,8'h00, 0,8'h00, 0, 1,8'hA2,0, 0,1,8'd0));
        vecs.push_back(mk(0, 1,8'hA4, 1,8'hB4, 0,8'h00, 0,8'h00, 0, 1,8'hB2,1, 1,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'hA3,0, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'hB3,1, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'hA4,0, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd0));
        // Backpressure on channel 2 with downstream stalled, then released.
        vecs.push_back(mk(1, 0,8'h00, 1,8'h21, 0,8'h00, 0,8'h00, 1, 0,8'h00,0, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 1,8'h22, 0,8'h00, 0,8'h00, 1, 1,8'h21,1, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 1,8'h23, 0,8'h00, 0,8'h00, 1, 1,8'h21,1, 0,1,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 1,8'h24, 0,8'h00, 0,8'h00, 1, 1,8'h21,1, 0,1,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 1,8'h24, 0,8'h00, 0,8'h00, 0, 1,8'h22,1, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 1,8'h24, 0,8'h00, 0,8'h00, 0, 1,8'h23,1, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'h24,1, 0,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd0));
        // Flush of a buffered entry, of the output beat, of an incoming
        // beat, and of a head that would otherwise be popped.
        vecs.push_back(mk(1, 1,8'h14, 0,8'h00, 0,8'h00, 0,8'h00, 1, 0,8'h00,0, 0,0,8'd0));
        vecs.push_back(mk(0, 1,8'h15, 0,8'h00, 0,8'h00, 0,8'h00, 1, 1,8'h14,0, 0,0,8'd0));
        vecs.push_back(mk(0, 1,8'h16, 0,8'h00, 0,8'h00, 0,8'h00, 1, 1,8'h14,0, 1,0,8'd0));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 1,8'h16, 0,8'h00, 1, 1,8'h14,0, 0,0,8'd1));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 1,8'h15,0, 0,0,8'd1));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd1));
        vecs.push_back(mk(0, 1,8'h16, 0,8'h00, 0,8'h00, 0,8'h00, 1, 0,8'h00,0, 0,0,8'd1));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 1, 1,8'h16,0, 0,0,8'd1));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 1,8'h16, 1, 1,8'h16,0, 0,0,8'd1));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 1,8'h16, 0,8'h00, 1, 0,8'h00,0, 0,0,8'd2));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 1, 0,8'h00,0, 0,0,8'd2));
        vecs.push_back(mk(0, 1,8'h30, 0,8'h00, 1,8'h30, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd3));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd3));
        vecs.push_back(mk(0, 1,8'h40, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd3));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 1,8'h40, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd4));
        vecs.push_back(mk(0, 0,8'h00, 0,8'h00, 0,8'h00, 0,8'h00, 0, 0,8'h00,0, 0,0,8'd4));

        // Reset values, asserted asynchronously before any clock edge.
        #1 reset = 1;
        #2;
        chk("rst.out_valid",   {31'b0, out_valid},   32'd0);
        chk("rst.out_address", {24'b0, out_address}, 32'd0);
        chk("rst.out_id",      {24'b0, out_id},      32'd0);
        chk("rst.out_src",     {31'b0, out_src},     32'd0);
        chk("rst.drop_count",  {24'b0, drop_count},  32'd0);
        chk("rst.out_stall_1", {31'b0, out_stall_1}, 32'd0);
        chk("rst.out_stall_2", {31'b0, out_stall_2}, 32'd0);
        @(posedge clk); #1;
        reset = 0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i]);
            @(posedge clk); #1;
            check_vec(i, vecs[i]);
        end

        // Drop counter saturation, including a two-drop cycle at 254.
        do_reset();
        in_valid_1 = 1; in_id_1 = 8'h77; in_address_1 = addr1(8'h77);
        flush_1 = 1; flush_id_1 = 8'h77;
        repeat (254) begin
            @(posedge clk); #1;
        end
        chk("sat.254", {24'b0, drop_count}, 32'd254);
        chk("sat.out_valid", {31'b0, out_valid}, 32'd0);
        in_valid_2 = 1; in_id_2 = 8'h77; in_address_2 = addr2(8'h77);
        flush_2 = 1; flush_id_2 = 8'h77;
        @(posedge clk); #1;
        chk("sat.dual", {24'b0, drop_count}, 32'd255);
        in_valid_2 = 0; flush_2 = 0;
        @(posedge clk); #1;
        chk("sat.hold", {24'b0, drop_count}, 32'd255);

        // Reset in the middle of traffic with both FIFOs full.
        do_reset();
        in_stall = 1;
        in_valid_1 = 1; in_id_1 = 8'h5F; in_address_1 = addr1(8'h5F);
        flush_1 = 1; flush_id_1 = 8'h5F;
        @(posedge clk); #1;
        flush_1 = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid_1 = 1; in_id_1 = 8'h50 + 8'(k); in_address_1 = addr1(in_id_1);
            in_valid_2 = 1; in_id_2 = 8'h60 + 8'(k); in_address_2 = addr2(in_id_2);
            @(posedge clk); #1;
        end
        chk("mid.pre_stall_1", {31'b0, out_stall_1}, 32'd1);
        chk("mid.pre_stall_2", {31'b0, out_stall_2}, 32'd1);
        chk("mid.pre_valid",   {31'b0, out_valid},   32'd1);
        chk("mid.pre_drop",    {24'b0, drop_count},  32'd1);
        reset = 1;
        #2;
        chk("mid.out_valid",   {31'b0, out_valid},   32'd0);
        chk("mid.out_address", {24'b0, out_address}, 32'd0);
        chk("mid.out_id",      {24'b0, out_id},      32'd0);
        chk("mid.out_src",     {31'b0, out_src},     32'd0);
        chk("mid.drop_count",  {24'b0, drop_count},  32'd0);
        chk("mid.out_stall_1", {31'b0, out_stall_1}, 32'd0);
        chk("mid.out_stall_2", {31'b0, out_stall_2}, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid.post%0d.out_valid", k), {31'b0, out_valid}, 32'd0);
            chk($sformatf("mid.post%0d.drop", k), {24'b0, drop_count}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stall_arbiter.md
STALL_ARBITER -- requirements
Module: stall_arbiter

Interface
REQ-001 Constants ADDRESS_WIDTH and ID_WIDTH SHALL come from defines.vh; the block has no parameters, and the per-channel FIFO depth is fixed at 2.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 in_address_1 / in_id_1 / in_valid_1  input  ADDRESS_WIDTH / ID_WIDTH / 1  channel-1 request beat.
REQ-005 out_stall_1  output  1  backpressure to channel 1.
REQ-006 flush_1 / flush_id_1  input  1 / ID_WIDTH  channel-1 flush request and target ID.
REQ-007 in_address_2 / in_id_2 / in_valid_2, out_stall_2, flush_2 / flush_id_2: same widths and meanings as the channel-1 signals, for channel 2.
REQ-008 out_address / out_id / out_valid  output  ADDRESS_WIDTH / ID_WIDTH / 1  merged downstream beat.
REQ-009 out_src  output  1  source of the downstream beat: 0 = channel 1, 1 = channel 2.
REQ-010 in_stall  input  1  downstream backpressure.
REQ-011 drop_count  output  8  saturating count of beats discarded by flushes.

Function
REQ-012 Each channel SHALL own a 2-entry FIFO holding {address, id}; count_N ranges 0..2.
REQ-013 out_stall_N SHALL be 1 exactly when count_N == 2, decoded directly from the count register.
REQ-014 Channel N SHALL accept a beat on a cycle only if in_valid_N = 1 and out_stall_N = 0; beats with in_valid_N = 0 SHALL be ignored.
REQ-015 Output register SHALL load when out_valid = 0 or in_stall = 0.
  - Load takes the round-robin winner among surviving FIFO heads.
  - If no head survives, out_valid SHALL go to 0.
REQ-016 While in_stall = 1 and out_valid = 1, out_address, out_id and out_src SHALL hold, except for flush per REQ-021.
REQ-017 Latency: no bypass; a beat accepted into an empty FIFO at edge k, with the output free, SHALL appear with out_valid = 1 after edge k+1.
REQ-018 Round-robin: priority pointer rr resets to channel 1.
  - Both heads valid: grant the rr channel.
  - One head valid: grant that channel.
  - After every grant, rr SHALL point to the non-granted channel.
REQ-019 Push and pop on the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 Flush on channel N (flush_N = 1) SHALL discard every channel-N FIFO entry whose id == flush_id_N.
  - Remaining entries SHALL be compacted in order.
  - A discarded head SHALL NOT be eligible for arbitration that cycle.
REQ-021 Flush on channel N SHALL also discard:
  - an accepted incoming channel-N beat with in_id_N == flush_id_N; the producer still sees it accepted;
  - the output beat, if out_valid = 1, in_stall = 1, out_src selects N and out_id == flush_id_N; out_valid SHALL then be 0 after the edge, unless a load per REQ-015 occurs.
REQ-022 A flush SHALL affect only its own channel; flushes on both channels in one cycle SHALL be processed independently.
REQ-023 drop_count SHALL increase by the number of beats discarded that cycle, saturating at 255.
REQ-024 An entry that is both popped and matched by a flush in the same cycle SHALL be dropped, not issued, and counted once.

Reset
REQ-025 On reset, outputs SHALL go to:
  - out_valid = 0, out_address = 0, out_id = 0, out_src = 0;
  - drop_count = 0, out_stall_1 = 0, out_stall_2 = 0.
REQ-026 On reset, count_1 = count_2 = 0 and rr = channel 1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and output beats without counting them as drops.

Verification
REQ-028 Single beat: after reset, ch1 beat addr 0x04, id 0x11, in_stall = 0 -> out_valid = 1, out_id = 0x11, out_src = 0, one cycle after acceptance.
REQ-029 Contention: both channels valid continuously, in_stall = 0 -> out_src alternates 0, 1, 0, 1 starting with 0; per-channel ids appear in order.
REQ-030 Backpressure: in_stall = 1 held, ch2 streaming ids 0x21.. -> out_valid = 1 with id 0x21 held; FIFO holds 0x22, 0x23; out_stall_2 = 1; release -> 0x21..0x24 emitted in order, none lost or duplicated.
REQ-031 Flush buffered: ch1 FIFO holds 0x15, 0x16; flush_1 with id 0x16 -> count_1 = 1, 0x16 never emitted, drop_count = 1.
REQ-032 Flush output: out_id = 0x16, out_src = 0, in_stall = 1; flush_1 with id 0x16 -> out_valid = 0 next cycle, drop_count += 1.
REQ-033 Reset mid-stream: both FIFOs full, then assert reset -> all outputs at reset values, drop_count = 0; no stale beat appears after release.
